// File: rtl/tft_pkg.sv
// Shared types and helpers for the PMOD TFT pixel writer: FSM states, the
// frame-start command byte and RGB888 -> RGB565 packing.
package tft_pkg;

  localparam logic [7:0] CMD_MEM_WRITE_DEFAULT = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_BYTE,
    ST_FRAME_CMD,
    ST_PIX_WAIT,
    ST_PIX_HI,
    ST_PIX_LO,
    ST_DONE
  } tft_state_e;

  // Result is {high byte, low byte} as sent on the bus.
  function automatic logic [15:0] rgb888_to_565(input logic [7:0] r,
                                                input logic [7:0] g,
                                                input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

endpackage

// File: rtl/tft_bus_byte.sv
// One 8080-style write cycle: wr_n low for WR_LOW_CYCLES, then high for
// WR_HIGH_CYCLES, with data/dc held for the whole byte.
module tft_bus_byte #(
  parameter int unsigned WR_LOW_CYCLES  = 2,
  parameter int unsigned WR_HIGH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       tx_dc,
  output logic       busy,
  output logic       done,
  output logic       wr_n,
  output logic [7:0] data,
  output logic       dc
);

  typedef enum logic [1:0] {PH_IDLE, PH_LOW, PH_HIGH} phase_e;

  phase_e     phase;
  logic [7:0] cnt;

  assign busy = (phase != PH_IDLE);
  // done marks the final high cycle so a new start can follow with no gap.
  assign done = (phase == PH_HIGH) && (cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= PH_IDLE;
      cnt   <= 8'd0;
      wr_n  <= 1'b1;
      data  <= 8'h00;
      dc    <= 1'b1;
    end else if (start && (!busy || done)) begin
      phase <= PH_LOW;
      cnt   <= 8'(WR_LOW_CYCLES - 1);
      wr_n  <= 1'b0;
      data  <= tx_byte;
      dc    <= tx_dc;
    end else begin
      case (phase)
        PH_LOW: begin
          if (cnt == 8'd0) begin
            phase <= PH_HIGH;
            cnt   <= 8'(WR_HIGH_CYCLES - 1);
            wr_n  <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PH_HIGH: begin
          if (cnt == 8'd0) phase <= PH_IDLE;
          else             cnt   <= cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tft_pixel_writer.sv
// Streams RGB888 pixels to a PMOD TFT as RGB565 byte pairs behind a
// memory-write command, and forwards single init bytes from registers.
module tft_pixel_writer
  import tft_pkg::*;
#(
  parameter int unsigned WR_LOW_CYCLES  = 2,
  parameter int unsigned WR_HIGH_CYCLES = 2,
  parameter logic [7:0]  CMD_MEM_WRITE  = CMD_MEM_WRITE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enable,
  input  logic       i_pixel_rdy,
  input  logic [7:0] i_red,
  input  logic [7:0] i_green,
  input  logic [7:0] i_blue,
  input  logic       i_last,
  output logic       o_pixel_stb,
  input  logic       i_cmd_stb,
  input  logic       i_cmd_dc,
  input  logic [7:0] i_cmd_data,
  output logic       o_cmd_busy,
  output logic       o_frame_done,
  output logic       o_cs_n,
  output logic       o_dc,
  output logic       o_wr_n,
  output logic       o_rd_n,
  output logic [7:0] o_data
);

  tft_state_e  state;
  logic [7:0]  cmd_byte;
  logic        cmd_dc;
  logic [7:0]  pix_lo;
  logic        pix_last;
  logic [15:0] pix_565;
  logic        bus_start;
  logic [7:0]  bus_byte;
  logic        bus_dc;
  logic        bus_busy;
  logic        bus_done;

  assign pix_565 = rgb888_to_565(i_red, i_green, i_blue);

  // Pixel handshake: i_pixel_rdy presents a pixel and holds it; o_pixel_stb is
  // high for the single PIX_WAIT cycle whose closing edge takes the pixel.
  assign o_pixel_stb  = (state == ST_PIX_WAIT) && i_enable && i_pixel_rdy;
  assign o_cs_n       = (state == ST_IDLE);
  assign o_cmd_busy   = (state != ST_IDLE);
  assign o_frame_done = (state == ST_DONE);
  assign o_rd_n       = 1'b1;

  always_comb begin
    bus_start = 1'b0;
    bus_byte  = 8'h00;
    bus_dc    = 1'b1;
    case (state)
      ST_CMD_BYTE: begin
        bus_start = !bus_busy;
        bus_byte  = cmd_byte;
        bus_dc    = cmd_dc;
      end
      ST_FRAME_CMD: begin
        bus_start = !bus_busy;
        bus_byte  = CMD_MEM_WRITE;
        bus_dc    = 1'b0;
      end
      ST_PIX_WAIT: begin
        bus_start = o_pixel_stb;
        bus_byte  = pix_565[15:8];
      end
      ST_PIX_HI: begin
        bus_start = bus_done;
        bus_byte  = pix_lo;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cmd_byte <= 8'h00;
      cmd_dc   <= 1'b0;
      pix_lo   <= 8'h00;
      pix_last <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_cmd_stb) begin
            cmd_byte <= i_cmd_data;
            cmd_dc   <= i_cmd_dc;
            state    <= ST_CMD_BYTE;
          end else if (i_enable && i_pixel_rdy) begin
            state <= ST_FRAME_CMD;
          end
        end
        ST_CMD_BYTE:  if (bus_done) state <= ST_IDLE;
        ST_FRAME_CMD: if (bus_done) state <= ST_PIX_WAIT;
        ST_PIX_WAIT: begin
          if (!i_enable) begin
            state <= ST_IDLE;
          end else if (i_pixel_rdy) begin
            pix_lo   <= pix_565[7:0];
            pix_last <= i_last;
            state    <= ST_PIX_HI;
          end
        end
        ST_PIX_HI: if (bus_done) state <= ST_PIX_LO;
        ST_PIX_LO: if (bus_done) state <= pix_last ? ST_DONE : ST_PIX_WAIT;
        ST_DONE:   state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  tft_bus_byte #(
    .WR_LOW_CYCLES (WR_LOW_CYCLES),
    .WR_HIGH_CYCLES(WR_HIGH_CYCLES)
  ) u_bus_byte (
    .clk    (clk),
    .rst    (rst),
    .start  (bus_start),
    .tx_byte(bus_byte),
    .tx_dc  (bus_dc),
    .busy   (bus_busy),
    .done   (bus_done),
    .wr_n   (o_wr_n),
    .data   (o_data),
    .dc     (o_dc)
  );

endmodule

// File: tb/tb_tft_pixel_writer.sv
// Bench for tft_pixel_writer: expected bus bytes queued from a plain-arithmetic
// RGB565 model and compared on every o_wr_n rising edge.
module tb_tft_pixel_writer;

  localparam int LOW  = 2;
  localparam int HIGH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_enable = 1'b0, i_pixel_rdy = 1'b0, i_last = 1'b0;
  logic [7:0] i_red = 8'h00, i_green = 8'h00, i_blue = 8'h00;
  logic       i_cmd_stb = 1'b0, i_cmd_dc = 1'b0;
  logic [7:0] i_cmd_data = 8'h00;
  logic       o_pixel_stb, o_cmd_busy, o_frame_done, o_cs_n, o_dc, o_wr_n, o_rd_n;
  logic [7:0] o_data;

  tft_pixel_writer dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_pixel_rdy(i_pixel_rdy),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue), .i_last(i_last),
    .o_pixel_stb(o_pixel_stb), .i_cmd_stb(i_cmd_stb), .i_cmd_dc(i_cmd_dc),
    .i_cmd_data(i_cmd_data), .o_cmd_busy(o_cmd_busy), .o_frame_done(o_frame_done),
    .o_cs_n(o_cs_n), .o_dc(o_dc), .o_wr_n(o_wr_n), .o_rd_n(o_rd_n), .o_data(o_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         tests = 0, fails = 0;
  logic [8:0] exp_q[$];            // {dc, data} in bus order
  int         stb_cnt = 0, done_cnt = 0;
  int         exp_stb = 0, exp_done = 0;
  bit         frame_open = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RGB565 from plain arithmetic: 5/6/5 bit fields as base-2048/32 digits.
  function automatic void push_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int word;
    word = (int'(r) / 8) * 2048 + (int'(g) / 4) * 32 + (int'(b) / 8);
    exp_q.push_back({1'b1, 8'(word / 256)});
    exp_q.push_back({1'b1, 8'(word % 256)});
  endfunction

  // ---------------- bus monitor / compare ----------------
  logic       prev_wr = 1'b1;
  int         low_cnt = 0, high_cnt = 1000;
  logic [7:0] fall_data = 8'h00;
  logic       fall_dc = 1'b0;
  bit         aborted = 0, stb_prev = 0;

  always @(negedge clk) begin
    check("rd_n_const", o_rd_n, 1);
    if (rst) begin
      if (!prev_wr || !o_wr_n) aborted = 1;
      high_cnt = 1000;
      stb_prev = 0;
    end else begin
      if (o_wr_n == 1'b0) begin
        if (prev_wr) begin
          check("wr_high_gap", high_cnt >= HIGH, 1);
          fall_data = o_data;
          fall_dc   = o_dc;
          low_cnt   = 1;
          aborted   = 0;
        end else begin
          low_cnt++;
          check("data_stable", {o_dc, o_data}, {fall_dc, fall_data});
        end
        check("cs_during_wr", o_cs_n, 0);
        check("stb_in_flight", o_pixel_stb, 0);
      end else if (!prev_wr) begin
        high_cnt = 1;
        if (!aborted) begin
          check("wr_low_width", low_cnt, LOW);
          check("data_at_rise", {o_dc, o_data}, {fall_dc, fall_data});
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_byte: got %0h, expected none", {fall_dc, fall_data});
          end else begin
            check("bus_byte", {fall_dc, fall_data}, exp_q.pop_front());
          end
        end
      end else begin
        high_cnt++;
      end
      if (stb_prev) check("stb_to_wr_latency", o_wr_n, 0);
      if (o_pixel_stb) begin
        stb_cnt++;
        check("stb_needs_rdy", i_pixel_rdy & i_enable, 1);
      end
      if (o_frame_done) begin
        done_cnt++;
        check("done_after_bytes", exp_q.size(), 0);
      end
      stb_prev = o_pixel_stb;
    end
    prev_wr = o_wr_n;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && o_cmd_busy; k++) tick();
    check("idle_timeout", o_cmd_busy, 0);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_frame_done();
    for (int k = 0; k < 300 && done_cnt < exp_done; k++) tick();
    check("frame_done_count", done_cnt, exp_done);
  endtask

  task automatic send_cmd(input logic dc, input logic [7:0] d);
    exp_q.push_back({dc, d});
    i_cmd_stb = 1'b1; i_cmd_dc = dc; i_cmd_data = d;
    tick();
    i_cmd_stb = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input bit last, input bit push_exp,
                            input bit with_cmd, input logic cdc, input logic [7:0] cdata);
    bit got;
    got = 0;
    if (with_cmd) exp_q.push_back({cdc, cdata});
    if (!frame_open) begin
      if (push_exp) exp_q.push_back({1'b0, 8'h2C});
      frame_open = 1;
    end
    i_red = r; i_green = g; i_blue = b; i_last = last; i_pixel_rdy = 1'b1;
    i_cmd_stb = with_cmd; i_cmd_dc = cdc; i_cmd_data = cdata;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (o_pixel_stb) begin
        got = 1;
        if (push_exp) push_pixel(r, g, b);
      end
      tick();
      i_cmd_stb = 1'b0;
    end
    i_pixel_rdy = 1'b0; i_last = 1'b0;
    if (got) exp_stb++;
    else check("pixel_timeout", 0, 1);
    if (last) begin
      frame_open = 0;
      exp_done++;
    end
  endtask

  task automatic rand_frame(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send_pixel(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), i == n - 1, 1, 0, 1'b0, 8'h00);
    end
    wait_frame_done();
    check("stb_count", stb_cnt, exp_stb);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int stb_before;

    repeat (3) tick();
    check("rst_cs_n", o_cs_n, 1);
    check("rst_wr_n", o_wr_n, 1);
    check("rst_dc", o_dc, 1);
    check("rst_data", o_data, 8'h00);
    check("rst_stb", o_pixel_stb, 0);
    check("rst_done", o_frame_done, 0);
    check("rst_busy", o_cmd_busy, 0);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_cs_n", o_cs_n, 1);
    check("idle_busy", o_cmd_busy, 0);

    // Single command byte: busy for exactly 5 cycles.
    send_cmd(1'b0, 8'h11);
    check("cmd_cs_low", o_cs_n, 0);
    n = 0;
    for (int k = 0; k < 50 && o_cmd_busy; k++) begin n++; tick(); end
    check("cmd_busy_cycles", n, 5);
    check("cmd_cs_after", o_cs_n, 1);
    wait_drain();

    // Random register bytes.
    for (int i = 0; i < 5; i++) begin
      wait_idle();
      send_cmd(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      wait_idle();
    end
    wait_drain();

    // Hand-computed frame: 2C, F800, 07E0, 001F.
    i_enable = 1'b1;
    exp_q.push_back(9'h02C);
    exp_q.push_back(9'h1F8); exp_q.push_back(9'h100);
    exp_q.push_back(9'h107); exp_q.push_back(9'h1E0);
    exp_q.push_back(9'h100); exp_q.push_back(9'h11F);
    stb_before = stb_cnt;
    send_pixel(8'hFF, 8'h00, 8'h00, 0, 0, 0, 1'b0, 8'h00);
    send_pixel(8'h00, 8'hFF, 8'h00, 0, 0, 0, 1'b0, 8'h00);
    send_pixel(8'h00, 8'h00, 8'hFF, 1, 0, 0, 1'b0, 8'h00);
    wait_frame_done();
    check("lit_stb_pulses", stb_cnt - stb_before, 3);
    check("lit_frame_done", done_cnt, 1);
    wait_drain();

    // Random frames.
    for (int f = 0; f < 4; f++) rand_frame($urandom_range(1, 5));

    // Enable dropped in PIX_WAIT: frame abandoned, next pixel restarts with 2C.
    send_pixel(8'($urandom_range(0, 255)), 8'h5A, 8'h3C, 0, 1, 0, 1'b0, 8'h00);
    wait_drain();
    repeat (3) tick();
    i_enable = 1'b0;
    repeat (2) tick();
    check("disable_cs_n", o_cs_n, 1);
    check("disable_busy", o_cmd_busy, 0);
    frame_open = 0;
    stb_before = stb_cnt;
    i_pixel_rdy = 1'b1; i_last = 1'b1;
    repeat (20) tick();
    check("disabled_no_stb", stb_cnt, stb_before);
    check("disabled_cs_n", o_cs_n, 1);
    check("disabled_no_done", done_cnt, exp_done);
    i_enable = 1'b1;
    send_pixel(8'h12, 8'h34, 8'h56, 1, 1, 0, 1'b0, 8'h00);
    wait_frame_done();
    wait_drain();

    // Command and pixel in the same idle cycle; mid-frame command dropped.
    wait_idle();
    send_pixel(8'hA0, 8'hB0, 8'hC0, 0, 1, 1, 1'b1, 8'hA5);
    i_cmd_stb = 1'b1; i_cmd_dc = 1'b0; i_cmd_data = 8'h99;
    tick();
    i_cmd_stb = 1'b0;
    send_pixel(8'h0F, 8'hF0, 8'h81, 1, 1, 0, 1'b0, 8'h00);
    wait_frame_done();
    wait_drain();
    check("stb_total", stb_cnt, exp_stb);

    // Reset while wr_n is low on a high byte.
    wait_idle();
    send_pixel(8'hC3, 8'h3C, 8'h7E, 0, 1, 0, 1'b0, 8'h00);
    for (int k = 0; k < 20 && o_wr_n; k++) tick();
    check("hi_byte_wr_low", o_wr_n, 0);
    rst = 1'b1;
    exp_q.delete();
    frame_open = 0;
    tick();
    check("midrst_wr_n", o_wr_n, 1);
    check("midrst_cs_n", o_cs_n, 1);
    check("midrst_busy", o_cmd_busy, 0);
    check("midrst_done", o_frame_done, 0);
    rst = 1'b0;
    repeat (15) tick();
    check("midrst_no_done", done_cnt, exp_done);
    check("midrst_idle_cs", o_cs_n, 1);

    // Recovery after reset.
    rand_frame(2);
    wait_drain();
    wait_idle();
    send_cmd(1'b1, 8'($urandom_range(0, 255)));
    wait_idle();
    wait_drain();
    check("final_done_count", done_cnt, exp_done);
    check("final_stb_count", stb_cnt, exp_stb);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tft_pixel_writer.md
Name: tft_pixel_writer

Overview:
- Downstream stage of the pixel reader. Consumes 24-bit RGB pixels over a rdy/stb handshake and drives an 8080-style 8-bit parallel bus to the PMOD TFT controller.
- Packs each pixel to RGB565 and sends it as two bus bytes.
- Prefixes every frame with the memory-write command; the last-pixel flag ends the frame.
- Also carries single command/data bytes from the register interface for controller initialisation.

Parameters:
- WR_LOW_CYCLES, 2, cycles o_wr_n is held low per byte (1..255).
- WR_HIGH_CYCLES, 2, cycles o_wr_n is held high after each byte (1..255).
- CMD_MEM_WRITE, 8'h2C, command byte sent at frame start.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_enable  in  1  pixel streaming permitted
- i_pixel_rdy  in  1  upstream pixel valid
- i_red  in  8  pixel red
- i_green  in  8  pixel green
- i_blue  in  8  pixel blue
- i_last  in  1  current pixel is last of frame
- o_pixel_stb  out  1  one-cycle pulse: pixel consumed
- i_cmd_stb  in  1  one-cycle request to send one byte
- i_cmd_dc  in  1  0 = command byte, 1 = data byte
- i_cmd_data  in  8  byte to send
- o_cmd_busy  out  1  high whenever FSM is not IDLE
- o_frame_done  out  1  one-cycle pulse after the last pixel's low byte completes
- o_cs_n  out  1  chip select, active low
- o_dc  out  1  data/command select
- o_wr_n  out  1  write strobe, active low
- o_rd_n  out  1  read strobe; constant 1
- o_data  out  8  bus data

Behaviour:
- Reset values: o_cs_n=1, o_wr_n=1, o_rd_n=1, o_dc=1, o_data=0, o_pixel_stb=0, o_frame_done=0, o_cmd_busy=0. The FSM goes to IDLE.
- Reset takes effect at the next edge even mid-byte. Any partial frame is abandoned with no frame_done.
- Byte cycle (shared by all states):
  - The FSM loads o_data/o_dc and drives o_wr_n low for WR_LOW_CYCLES, then high for WR_HIGH_CYCLES.
  - o_data/o_dc stay stable for the whole byte.
  - The controller latches on the o_wr_n rising edge.
  - Default byte time is 4 cycles.
- RGB565 packing:
  - High byte = {r[7:3], g[7:5]}.
  - Low byte = {g[4:2], b[7:3]}.
  - Both bytes are sent with dc=1.
- States:
  - IDLE:
    - o_cs_n=1.
    - i_cmd_stb → latch byte → CMD_BYTE. The command wins if it coincides with i_pixel_rdy.
    - Else if i_enable && i_pixel_rdy → FRAME_CMD. The pixel is not yet consumed.
  - CMD_BYTE: one byte with dc=i_cmd_dc → IDLE.
  - FRAME_CMD: CMD_MEM_WRITE with dc=0 → PIX_WAIT.
  - PIX_WAIT:
    - If !i_enable → IDLE (cs_n deasserts, no frame_done).
    - Else if i_pixel_rdy: o_pixel_stb=1 for one cycle, latch the packed pixel and i_last on that same edge → PIX_HI.
  - PIX_HI: high byte → PIX_LO.
  - PIX_LO: low byte. Then if latched last → DONE, else → PIX_WAIT.
  - DONE: o_frame_done=1 for one cycle → IDLE.
- o_cs_n=0 in every state except IDLE.
- o_pixel_stb is asserted only in PIX_WAIT and is never issued while a byte is in flight.
- Pixel-to-strobe latency: o_wr_n falls on the cycle after o_pixel_stb.
- i_cmd_stb outside IDLE is ignored with no queueing; software polls o_cmd_busy.
- An i_last pixel with i_enable low is never consumed.
- Sustained pixel rate at defaults: 1 pixel per 9 cycles (1 PIX_WAIT cycle + 2 bytes × 4).
- Timing counter: 8 bits wide, reloaded at each phase change.

Decomposition:
- Shared package tft_pkg holds:
  - the state enum;
  - the CMD_MEM_WRITE default;
  - an rgb888_to_565 function.
- One natural sub-module, tft_bus_byte. It owns the o_wr_n low/high timing and counter, takes start/byte/dc in, and returns a one-cycle done. The FSM sequences it.

Test Plan:
- Reset then idle → all outputs at reset values; o_rd_n=1 throughout the whole run.
- i_cmd_stb with dc=0, data=8'h11 → o_cs_n low, o_dc=0, o_data=8'h11, o_wr_n low 2 cycles then high 2, back to IDLE; o_cmd_busy high exactly 5 cycles.
- i_enable=1, three pixels FF/00/00, 00/FF/00, 00/00/FF with last on the third:
  - bus shows 2C(dc=0), F8 00, 07 E0, 00 1F (dc=1);
  - exactly 3 o_pixel_stb pulses;
  - one o_frame_done pulse after the final low byte.
- i_enable dropped in PIX_WAIT mid-frame → return to IDLE with o_cs_n=1, no frame_done. Next pixel triggers a fresh 8'h2C.
- i_cmd_stb and i_pixel_rdy asserted in the same IDLE cycle → command byte sent first, then 8'h2C and the pixel. i_cmd_stb issued mid-frame is dropped.
- rst asserted while o_wr_n is low on a high byte → next cycle o_wr_n=1, o_cs_n=1, FSM IDLE; no o_frame_done.
